// File: rtl/coin_key_filter.sv
// rtl/coin_key_filter.sv - synchronise, debounce and arbitrate the two active-low coin keys.
// Optional macro COIN_DEFER_EN: defer a colliding half-coin hit by one cycle instead of dropping it.
module coin_key_filter #(
  parameter logic [19:0] CNT_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_one,
  input  logic key_half,
  output logic po_coin_one,
  output logic po_coin_half
);

  localparam int unsigned CH_ONE  = 0;
  localparam int unsigned CH_HALF = 1;

  logic [1:0]  key_raw;
  logic [1:0]  meta_q, meta_d;
  logic [1:0]  sync_q, sync_d;
  logic [19:0] cnt_q [2];
  logic [19:0] cnt_d [2];
  logic [1:0]  hit;
  logic        coin_one_q, coin_one_d;
  logic        coin_half_q, coin_half_d;
`ifdef COIN_DEFER_EN
  logic        pend_q, pend_d;
`endif

  assign key_raw = {key_half, key_one};

  // Per-channel debounce; a hit also needs the younger synchroniser stage low,
  // so the key must still be pressed on the sample that completes the hold.
  always_comb begin
    meta_d = key_raw;
    sync_d = meta_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + 20'd1;
      end
      hit[i] = !sync_q[i] && !meta_q[i] && (cnt_q[i] == CNT_MAX - 20'd1);
    end
  end

  // Arbitration: the one-yuan hit always wins a collision.
  always_comb begin
    coin_one_d  = hit[CH_ONE];
    coin_half_d = 1'b0;
`ifdef COIN_DEFER_EN
    pend_d = pend_q;
    if (hit[CH_ONE]) begin
      pend_d = pend_q | hit[CH_HALF];
    end else if (hit[CH_HALF] || pend_q) begin
      coin_half_d = 1'b1;
      pend_d      = 1'b0;
    end
`else
    coin_half_d = hit[CH_HALF] & ~hit[CH_ONE];
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q      <= 2'b11;
      sync_q      <= 2'b11;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      coin_one_q  <= 1'b0;
      coin_half_q <= 1'b0;
`ifdef COIN_DEFER_EN
      pend_q      <= 1'b0;
`endif
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      coin_one_q  <= coin_one_d;
      coin_half_q <= coin_half_d;
`ifdef COIN_DEFER_EN
      pend_q      <= pend_d;
`endif
    end
  end

  assign po_coin_one  = coin_one_q;
  assign po_coin_half = coin_half_q;

endmodule

// File: tb/tb_coin_key_filter.sv
// tb/tb_coin_key_filter.sv - scoreboard bench for coin_key_filter with CNT_MAX = 4.
module tb_coin_key_filter;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_one = 1'b1;
  logic key_half = 1'b1;
  logic po_coin_one;
  logic po_coin_half;

  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  coin_key_filter #(.CNT_MAX(20'd4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_one      (key_one),
    .key_half     (key_half),
    .po_coin_one  (po_coin_one),
    .po_coin_half (po_coin_half)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) edge_n <= edge_n + 1;

  // Every non-zero output cycle must match the oldest queued expectation exactly.
  always @(negedge sys_clk) begin
    logic [1:0] obs;
    exp_t       e;
    obs = {po_coin_half, po_coin_one};
    if (sys_rst_n && obs != 2'b00) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse edge=%0d got=%b required=00", edge_n, obs);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != edge_n || e.val !== obs) begin
          errors++;
          $display("FAIL pulse edge=%0d got=%b required edge=%0d val=%b", edge_n, obs, e.cyc, e.val);
        end
      end
    end
  end

  task automatic push_exp(input int cyc, input logic [1:0] val);
    exp_t e;
    e.cyc = cyc;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset;
    key_one = 1'b1;
    key_half = 1'b1;
    sys_rst_n = 1'b0;
    wait_neg(3);
    checks++;
    if ({po_coin_half, po_coin_one} !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=00", {po_coin_half, po_coin_one});
    end
    sys_rst_n = 1'b1;
    wait_neg(6);
    checks++;
    if ({po_coin_half, po_coin_one} !== 2'b00) begin
      errors++;
      $display("FAIL idle_outputs got=%b required=00", {po_coin_half, po_coin_one});
    end
  endtask

  task automatic test_clean_press;
    int base;
    key_one = 1'b0;
    base = edge_n + 1;
    push_exp(base + 5, 2'b01);
    wait_neg(20);
    key_one = 1'b1;
    wait_neg(8);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL clean_press_missing got=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_bounce;
    int base;
    for (int r = 0; r < 4; r++) begin
      key_half = 1'b0;
      wait_neg(2);
      key_half = 1'b1;
      wait_neg(1);
    end
    key_half = 1'b0;
    base = edge_n + 1;
    push_exp(base + 5, 2'b10);
    wait_neg(15);
    key_half = 1'b1;
    wait_neg(8);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_missing got=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_short_press;
    key_one = 1'b0;
    wait_neg(4);
    key_one = 1'b1;
    wait_neg(10);
    checks++;
    if ({po_coin_half, po_coin_one} !== 2'b00 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL short_press got=%b required=00", {po_coin_half, po_coin_one});
      sb_q.delete();
    end
  endtask

  task automatic test_simultaneous;
    int base;
    key_one = 1'b0;
    key_half = 1'b0;
    base = edge_n + 1;
    push_exp(base + 5, 2'b01);
`ifdef COIN_DEFER_EN
    push_exp(base + 6, 2'b10);
`endif
    wait_neg(20);
    key_one = 1'b1;
    key_half = 1'b1;
    wait_neg(8);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous_missing got=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int post;
    key_one = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({po_coin_half, po_coin_one} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%b required=00", {po_coin_half, po_coin_one});
    end
    wait_neg(1);
    sys_rst_n = 1'b1;
    post = edge_n + 1;
    push_exp(post + 5, 2'b01);
    wait_neg(15);
    key_one = 1'b1;
    wait_neg(8);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_missing got=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_async_clear;
    int post;
    key_half = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    checks++;
    if ({po_coin_half, po_coin_one} !== 2'b10) begin
      errors++;
      $display("FAIL async_pulse_high got=%b required=10", {po_coin_half, po_coin_one});
    end
    #1;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({po_coin_half, po_coin_one} !== 2'b00) begin
      errors++;
      $display("FAIL async_clear got=%b required=00", {po_coin_half, po_coin_one});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    post = edge_n + 1;
    push_exp(post + 5, 2'b10);
    wait_neg(12);
    key_half = 1'b1;
    wait_neg(8);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL async_repress_missing got=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    int base;
    key_half = 1'b0;
    base = edge_n + 1;
    push_exp(base + 5, 2'b10);
    wait_neg(8);
    key_half = 1'b1;
    wait_neg(2);
    key_half = 1'b0;
    push_exp(base + 15, 2'b10);
    wait_neg(8);
    key_half = 1'b1;
    wait_neg(8);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_missing got=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_press();
    test_simultaneous();
    test_reset_mid();
    test_async_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
